// File: rtl/seg_pkg.sv
// Shared font, select and phase definitions for the 7-segment scan driver (active-low encodings).
package seg_pkg;

    typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEL_OFF   = 8'hFF;

    // Index 0 is the rightmost entry: hex digits 0..F, dp always off.
    localparam logic [15:0][7:0] SEG_FONT = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

    // Phase n enables digit n of both banks: sel bits 7-n (bank A) and 3-n (bank B).
    localparam logic [3:0][7:0] SEL_ON = {8'hEE, 8'hDD, 8'hBB, 8'h77};

    function automatic phase_t next_phase(input phase_t p);
        return phase_t'(p + 2'd1);
    endfunction

    // Per-digit "show" mask for one 16-bit bank; digit 0 is always shown.
    function automatic logic [3:0] lzb_show(input logic [15:0] w);
        logic [3:0] s;
        s[3] = |w[15:12];
        s[2] = s[3] | (|w[11:8]);
        s[1] = s[2] | (|w[7:4]);
        s[0] = 1'b1;
        return s;
    endfunction

endpackage

// File: rtl/seg_hex_font.sv
// Hex nibble to active-low 7-segment pattern. Latency: combinational.
// Backpressure: none.
module seg_hex_font
    import seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] pattern
);

    assign pattern = SEG_FONT[nibble];

endmodule

// File: rtl/seg_scan_driver.sv
// Two-bank 4-digit multiplexed 7-segment scanner; outputs registered, 1 clk after phase/blank state.
// Backpressure: none (load always accepted). Define SEG_LZB_EN for per-bank leading-zero blanking.
module seg_scan_driver
    import seg_pkg::*;
#(
    parameter int DIV            = 50000,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] value,
    input  logic        load,
    output logic [7:0]  seg_a,
    output logic [7:0]  seg_b,
    output logic [7:0]  sel,
    output logic [1:0]  phase
);

    localparam int             PW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0]  PRE_LAST = PW'(DIV - 1);
    localparam logic [7:0]     POL      = (SEG_ACTIVE_LOW != 0) ? 8'h00 : 8'hFF;

    logic [31:0]   shadow_q;
    logic [PW-1:0] presc_q;
    phase_t        phase_q;
    logic          blank_q;
    logic [3:0]    nib_a;
    logic [3:0]    nib_b;
    logic [7:0]    font_a;
    logic [7:0]    font_b;
    logic          show_a;
    logic          show_b;

    // Load resyncs the scan to digit 0 and wins over a coincident prescaler wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_q <= '0;
            presc_q  <= '0;
            phase_q  <= PH0;
            blank_q  <= 1'b1;
        end else if (load) begin
            shadow_q <= value;
            presc_q  <= '0;
            phase_q  <= PH0;
            blank_q  <= 1'b1;
        end else if (presc_q == PRE_LAST) begin
            presc_q  <= '0;
            phase_q  <= next_phase(phase_q);
            blank_q  <= 1'b1;
        end else begin
            presc_q  <= presc_q + PW'(1);
            blank_q  <= 1'b0;
        end
    end

`ifdef SEG_LZB_EN
    logic [7:0] lzb_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lzb_q <= 8'h11;
        end else if (load) begin
            lzb_q <= {lzb_show(value[31:16]), lzb_show(value[15:0])};
        end
    end

    assign show_a = lzb_q[{1'b0, phase_q}];
    assign show_b = lzb_q[{1'b1, phase_q}];
`else
    assign show_a = 1'b1;
    assign show_b = 1'b1;
`endif

    assign nib_a = shadow_q[{1'b0, phase_q, 2'b00} +: 4];
    assign nib_b = shadow_q[{1'b1, phase_q, 2'b00} +: 4];

    seg_hex_font u_font_a (.nibble(nib_a), .pattern(font_a));
    seg_hex_font u_font_b (.nibble(nib_b), .pattern(font_b));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel   <= SEL_OFF ^ POL;
            seg_a <= SEG_BLANK ^ POL;
            seg_b <= SEG_BLANK ^ POL;
        end else if (blank_q) begin
            sel   <= SEL_OFF ^ POL;
            seg_a <= SEG_BLANK ^ POL;
            seg_b <= SEG_BLANK ^ POL;
        end else begin
            sel   <= SEL_ON[phase_q] ^ POL;
            seg_a <= (show_a ? font_a : SEG_BLANK) ^ POL;
            seg_b <= (show_b ? font_b : SEG_BLANK) ^ POL;
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Self-checking bench for seg_scan_driver with DIV=4, active-low outputs.
module tb_seg_scan_driver;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] value;
    logic        load;
    logic [7:0]  seg_a;
    logic [7:0]  seg_b;
    logic [7:0]  sel;
    logic [1:0]  phase;

    always #5 clk = ~clk;

    seg_scan_driver #(.DIV(4), .SEG_ACTIVE_LOW(1)) dut (
        .clk   (clk),
        .reset (reset),
        .value (value),
        .load  (load),
        .seg_a (seg_a),
        .seg_b (seg_b),
        .sel   (sel),
        .phase (phase)
    );

    typedef struct {
        logic [7:0] sel;
        logic [7:0] a;
        logic [7:0] b;
        logic [1:0] ph;
    } exp_t;

    typedef struct {
        logic [31:0]      value;
        logic [3:0][7:0]  ea;
        logic [3:0][7:0]  eb;
    } vec_t;

    exp_t            sb[$];
    vec_t            vecs[4];
    logic [3:0][7:0] sel_tab;
    int              checks = 0;
    int              errors = 0;
    string           tag;

    task automatic check_now(input string name, input logic [7:0] es, input logic [7:0] ea,
                             input logic [7:0] eb, input logic [1:0] ep);
        checks++;
        if (sel !== es || seg_a !== ea || seg_b !== eb || phase !== ep) begin
            errors++;
            $display("FAIL %s: got sel=%h seg_a=%h seg_b=%h phase=%0d, want sel=%h seg_a=%h seg_b=%h phase=%0d",
                     name, sel, seg_a, seg_b, phase, es, ea, eb, ep);
        end
    endtask

    // One clock; sample 1 time unit after the edge and retire one expectation if queued.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_now(tag, e.sel, e.a, e.b, e.ph);
        end
    endtask

    task automatic push_one(input logic [7:0] s, input logic [7:0] a, input logic [7:0] b,
                            input logic [1:0] p);
        exp_t e;
        e.sel = s; e.a = a; e.b = b; e.ph = p;
        sb.push_back(e);
    endtask

    // Expectations for edges 1..n after a resync: blank edge, then 3 lit edges per phase.
    task automatic push_scan(input logic [3:0][7:0] ea, input logic [3:0][7:0] eb, input int n);
        for (int k = 1; k <= n; k++) begin
            int p;
            logic [1:0] ph;
            p  = (k - 1) / 4;
            ph = 2'((k / 4) % 4);
            if ((k - 1) % 4 == 0)
                push_one(8'hFF, 8'hFF, 8'hFF, ph);
            else
                push_one(sel_tab[p], ea[p], eb[p], ph);
        end
    endtask

    task automatic do_load(input logic [31:0] v);
        value = v;
        load  = 1'b1;
        step();
        load  = 1'b0;
    endtask

    initial begin
        sel_tab = {8'hEE, 8'hDD, 8'hBB, 8'h77};
        vecs[0] = '{32'h12345678, {8'h92, 8'h82, 8'hF8, 8'h80}, {8'hF9, 8'hA4, 8'hB0, 8'h99}};
        vecs[1] = '{32'hAAAAAAAA, {8'h88, 8'h88, 8'h88, 8'h88}, {8'h88, 8'h88, 8'h88, 8'h88}};
        vecs[2] = '{32'h9ABCDEF0, {8'hA1, 8'h86, 8'h8E, 8'hC0}, {8'h90, 8'h88, 8'h83, 8'hC6}};
        vecs[3] = '{32'h10203040, {8'hB0, 8'hC0, 8'h99, 8'hC0}, {8'hF9, 8'hC0, 8'hA4, 8'hC0}};

        reset = 1'b1;
        load  = 1'b0;
        value = 32'h0;
        #1;
        check_now("reset_state", 8'hFF, 8'hFF, 8'hFF, 2'd0);
        step();
        step();
        reset = 1'b0;
        tag = "reset_release";
        push_one(8'hFF, 8'hFF, 8'hFF, 2'd0);
        push_one(8'h77, 8'hC0, 8'hC0, 2'd0);
        step();
        step();

        // Each word: one full scan after load, then a second scan with value changed but not loaded.
        for (int i = 0; i < 4; i++) begin
            do_load(vecs[i].value);
            $sformat(tag, "scan_%08h", vecs[i].value);
            push_scan(vecs[i].ea, vecs[i].eb, 16);
            repeat (16) step();
            value = ~vecs[i].value;
            $sformat(tag, "hold_%08h", vecs[i].value);
            push_scan(vecs[i].ea, vecs[i].eb, 16);
            repeat (16) step();
        end

        tag = "load_held";
        load = 1'b1;
        for (int i = 0; i < 3; i++) begin
            value = (i == 2) ? vecs[2].value : 32'h5555_0000 + 32'(i);
            push_one(8'hFF, 8'hFF, 8'hFF, 2'd0);
            step();
        end
        load = 1'b0;
        tag = "after_held";
        push_scan(vecs[2].ea, vecs[2].eb, 16);
        repeat (16) step();

        do_load(vecs[0].value);
        tag = "pre_wrap";
        push_scan(vecs[0].ea, vecs[0].eb, 11);
        repeat (11) step();
        value = vecs[2].value;
        load  = 1'b1;
        tag = "load_at_wrap";
        push_one(8'hDD, 8'h82, 8'hA4, 2'd0);
        step();
        load = 1'b0;
        tag = "post_wrap";
        push_scan(vecs[2].ea, vecs[2].eb, 16);
        repeat (16) step();

        do_load(vecs[0].value);
        tag = "pre_reset";
        push_scan(vecs[0].ea, vecs[0].eb, 14);
        repeat (14) step();
        #2;
        reset = 1'b1;
        #1;
        check_now("async_reset", 8'hFF, 8'hFF, 8'hFF, 2'd0);
        step();
        reset = 1'b0;
        tag = "reset_mid";
        push_one(8'hFF, 8'hFF, 8'hFF, 2'd0);
        push_one(8'h77, 8'hC0, 8'hC0, 2'd0);
        step();
        step();

`ifdef SEG_LZB_EN
        do_load(32'h000A0000);
        tag = "lzb";
        push_scan({8'hFF, 8'hFF, 8'hFF, 8'hC0}, {8'hFF, 8'hFF, 8'hFF, 8'h88}, 16);
        repeat (16) step();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
